// File: rtl/uart_tx_queue.sv
// Buffered front end for the 6-bit UART transmitter: a FIFO feeding a launch/wait sequencer.
// Optional inter-frame gap state is enabled by defining UART_TXQ_GAP_EN.
//
//   state    | meaning
//   Q_IDLE   | waiting for a queued word and an idle transmitter
//   Q_LAUNCH | start pulse out, FIFO head popped at the end of this cycle
//   Q_WAIT   | frame in flight, waiting for the transmitter's done pulse
//   Q_GAP    | extra stop time after done (UART_TXQ_GAP_EN only)
module uart_tx_queue #(
   parameter int DEPTH          = 16,
   parameter int DEPTH_LOG2     = 4,
   parameter int GAP_TICKS      = 243,
   parameter int GAP_TICKS_SIZE = 8
) (
   input  logic                  in_clk,
   input  logic                  in_rst,
   input  logic                  in_wr_valid,
   input  logic [5:0]            in_wr_data,
   output logic                  out_wr_ready,
   output logic [DEPTH_LOG2:0]   out_level,
   output logic                  out_empty,
   output logic                  out_overflow,
   input  logic                  in_ovf_clear,
   output logic                  out_tx_start,
   output logic [5:0]            out_tx_data,
   input  logic                  in_tx_busy,
   input  logic                  in_tx_done,
   output logic                  out_idle
);

   if (DEPTH < 2 || DEPTH != (1 << DEPTH_LOG2)) begin : g_bad_depth
      $error("uart_tx_queue: DEPTH must be a power of two >= 2 matching DEPTH_LOG2");
   end
   if (GAP_TICKS < 1 || GAP_TICKS_SIZE < 1) begin : g_bad_gap
      $error("uart_tx_queue: GAP_TICKS and GAP_TICKS_SIZE must be positive");
   end

   localparam logic [DEPTH_LOG2:0]   FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      Q_IDLE   = 2'd0,
      Q_LAUNCH = 2'd1,
`ifdef UART_TXQ_GAP_EN
      Q_WAIT   = 2'd2,
      Q_GAP    = 2'd3
`else
      Q_WAIT   = 2'd2
`endif
   } state_t;

   logic [5:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   state_t                state;
   logic                  push;
   logic                  pop;

`ifdef UART_TXQ_GAP_EN
   localparam logic [GAP_TICKS_SIZE-1:0] GAP_LAST = GAP_TICKS_SIZE'(GAP_TICKS - 1);
   localparam logic [GAP_TICKS_SIZE-1:0] GAP_ONE  = GAP_TICKS_SIZE'(1);
   logic [GAP_TICKS_SIZE-1:0] gap_cnt;
`endif

   // Ready is decoded from the registered level, so a pop in the same cycle cannot free a slot.
   assign out_wr_ready = (level != FULL_LVL);
   assign out_empty    = (level == '0);
   assign out_level    = level;
   assign push         = in_wr_valid && out_wr_ready;
   assign pop          = (state == Q_LAUNCH);
   assign out_tx_start = pop;
   assign out_idle     = (state == Q_IDLE) && out_empty;

   always_ff @(posedge in_clk) begin
      if (push) mem[wr_ptr] <= in_wr_data;
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         level        <= '0;
         out_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)      level <= level + LVL_ONE;
         else if (pop && !push) level <= level - LVL_ONE;
         if (in_ovf_clear)                     out_overflow <= 1'b0;
         else if (in_wr_valid && !out_wr_ready) out_overflow <= 1'b1;
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         state       <= Q_IDLE;
         out_tx_data <= '0;
`ifdef UART_TXQ_GAP_EN
         gap_cnt     <= '0;
`endif
      end else begin
         case (state)
            Q_IDLE: begin
               if (!out_empty && !in_tx_busy) begin
                  state       <= Q_LAUNCH;
                  out_tx_data <= mem[rd_ptr];
               end
            end
            Q_LAUNCH: state <= Q_WAIT;
            Q_WAIT: begin
`ifdef UART_TXQ_GAP_EN
               if (in_tx_done) state <= Q_GAP;
`else
               if (in_tx_done) state <= Q_IDLE;
`endif
            end
`ifdef UART_TXQ_GAP_EN
            Q_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  state   <= Q_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_ONE;
               end
            end
`endif
            default: state <= Q_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a word-queue reference model plus a transmitter responder.
// Builds for either setting of UART_TXQ_GAP_EN (gap of 4 ticks when enabled).
module tb_uart_tx_queue;
   localparam int DEPTH  = 16;
   localparam int DL     = 4;
   localparam int TX_LEN = 10;
   localparam int GAP_P  = 4;
`ifdef UART_TXQ_GAP_EN
   localparam int M_GAP  = GAP_P;
`else
   localparam int M_GAP  = 0;
`endif
   // Cycles from the sampled done pulse to the sampled next start pulse.
   localparam int DELTA  = M_GAP + 2;

   logic          in_clk, in_rst, in_wr_valid, in_ovf_clear, in_tx_busy, in_tx_done;
   logic [5:0]    in_wr_data;
   logic          out_wr_ready, out_empty, out_overflow, out_tx_start, out_idle;
   logic [DL:0]   out_level;
   logic [5:0]    out_tx_data;

   uart_tx_queue #(.DEPTH(DEPTH), .DEPTH_LOG2(DL), .GAP_TICKS(GAP_P), .GAP_TICKS_SIZE(8)) dut (
      .in_clk(in_clk), .in_rst(in_rst), .in_wr_valid(in_wr_valid), .in_wr_data(in_wr_data),
      .out_wr_ready(out_wr_ready), .out_level(out_level), .out_empty(out_empty),
      .out_overflow(out_overflow), .in_ovf_clear(in_ovf_clear), .out_tx_start(out_tx_start),
      .out_tx_data(out_tx_data), .in_tx_busy(in_tx_busy), .in_tx_done(in_tx_done),
      .out_idle(out_idle)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Reference model: queued words, frame-in-flight flag, launch-this-cycle flag, gap countdown.
   logic [5:0] q[$];
   bit         m_active, m_launching, m_ovf;
   logic [5:0] m_data;
   int         m_gap;

   // Transmitter responder and logs.
   int         tx_cnt;
   bit         tx_force;
   logic [5:0] starts[$];
   int         start_cycs[$];
   int         dones[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_idle();
      return !m_active && m_gap == 0 && q.size() == 0;
   endfunction

   task automatic tick();
      bit rst, push, drop, nl, pop, done_ok, clr;
      logic [5:0] head, wdata;
      rst     = in_rst;
      clr     = in_ovf_clear;
      pop     = m_launching;
      push    = in_wr_valid && q.size() < DEPTH;
      drop    = in_wr_valid && q.size() >= DEPTH;
      nl      = !m_active && m_gap == 0 && q.size() > 0 && !in_tx_busy;
      done_ok = m_active && !m_launching && in_tx_done;
      head    = (q.size() > 0) ? q[0] : 6'd0;
      wdata   = in_wr_data;
      @(posedge in_clk);
      #1;
      cyc++;
      if (rst) begin
         q.delete();
         m_active = 0; m_launching = 0; m_ovf = 0; m_data = '0; m_gap = 0;
         tx_cnt = 0; in_tx_done = 0;
      end else begin
         if (clr) m_ovf = 0;
         else if (drop) m_ovf = 1;
         if (done_ok) begin
            m_active = 0;
            m_gap = M_GAP;
         end else if (m_gap > 0) begin
            m_gap--;
         end
         if (nl) begin
            m_active = 1;
            m_data = head;
         end
         m_launching = nl;
         if (pop) void'(q.pop_front());
         if (push) q.push_back(wdata);
         in_tx_done = 0;
         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
               in_tx_done = 1;
               dones.push_back(cyc);
            end
         end
         if (out_tx_start) begin
            tx_cnt = TX_LEN;
            starts.push_back(out_tx_data);
            start_cycs.push_back(cyc);
         end
      end
      in_tx_busy = tx_force || tx_cnt > 0;
      check("tx_start", 32'(out_tx_start), 32'(m_launching));
      check("tx_data",  32'(out_tx_data),  32'(m_data));
      check("level",    32'(out_level),    32'(q.size()));
      check("empty",    32'(out_empty),    32'(q.size() == 0));
      check("wr_ready", 32'(out_wr_ready), 32'(q.size() < DEPTH));
      check("overflow", 32'(out_overflow), 32'(m_ovf));
      check("idle",     32'(out_idle),     32'(m_idle()));
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((!m_idle() || tx_cnt > 0 || in_tx_done) && n < budget) begin
         tick();
         n++;
      end
      check("wait_idle_in_budget", 32'(n < budget), 32'd1);
   endtask

   task automatic clear_logs();
      starts.delete(); start_cycs.delete(); dones.delete();
   endtask

   logic [5:0] exp_words[$];
   int wcyc, acc, budget;

   initial begin
      in_rst = 1; in_wr_valid = 0; in_wr_data = '0; in_ovf_clear = 0;
      in_tx_busy = 0; in_tx_done = 0; tx_force = 0; tx_cnt = 0;
      m_active = 0; m_launching = 0; m_ovf = 0; m_data = '0; m_gap = 0;
      tick(); tick();
      in_rst = 0;
      tick();

      // Single word latency.
      clear_logs();
      in_wr_valid = 1; in_wr_data = 6'h2A;
      tick(); wcyc = cyc;
      in_wr_valid = 0;
      check("lat_level_after_write", 32'(out_level), 32'd1);
      wait_idle(60);
      check("lat_num_starts", 32'(starts.size()), 32'd1);
      if (starts.size() == 1) begin
         check("lat_start_cycle", 32'(start_cycs[0] - wcyc), 32'd1);
         check("lat_start_data", 32'(starts[0]), 32'h2A);
      end
      check("lat_idle_after_done", 32'(out_idle), 32'd1);

      // Three back-to-back words.
      clear_logs();
      for (int i = 1; i <= 3; i++) begin
         in_wr_valid = 1; in_wr_data = 6'(i);
         tick();
      end
      in_wr_valid = 0;
      wait_idle(150);
      check("b2b_num_starts", 32'(starts.size()), 32'd3);
      for (int i = 0; i < starts.size() && i < 3; i++)
         check("b2b_order", 32'(starts[i]), 32'(i + 1));
      for (int i = 1; i < start_cycs.size() && i <= dones.size(); i++)
         check("b2b_done_to_start", 32'(start_cycs[i] - dones[i-1]), 32'(DELTA));

      // Overflow with transmitter held busy.
      tx_force = 1; in_tx_busy = 1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         in_wr_valid = 1; in_wr_data = 6'($urandom);
         tick();
      end
      in_wr_valid = 0;
      check("ovf_level_full", 32'(out_level), 32'(DEPTH));
      check("ovf_ready_low", 32'(out_wr_ready), 32'd0);
      check("ovf_set", 32'(out_overflow), 32'd1);
      tick(); tick(); tick();
      check("ovf_sticky", 32'(out_overflow), 32'd1);
      in_ovf_clear = 1; tick(); in_ovf_clear = 0;
      check("ovf_cleared", 32'(out_overflow), 32'd0);
      in_wr_valid = 1; in_ovf_clear = 1; in_wr_data = 6'h3F; tick();
      in_wr_valid = 0; in_ovf_clear = 0;
      check("ovf_clear_priority", 32'(out_overflow), 32'd0);

      // Write at the pop edge of a full queue, then drain 2*DEPTH words through the wrap.
      clear_logs();
      exp_words = q;
      tx_force = 0; in_tx_busy = (tx_cnt > 0);
      for (int n = 0; n < 20 && !out_tx_start; n++) tick();
      check("pop_launch_seen", 32'(out_tx_start), 32'd1);
      in_wr_valid = 1; in_wr_data = 6'h15; tick(); in_wr_valid = 0;
      check("pop_edge_level", 32'(out_level), 32'(DEPTH - 1));
      check("pop_edge_ovf", 32'(out_overflow), 32'd1);
      in_ovf_clear = 1; tick(); in_ovf_clear = 0;
      acc = 0; budget = 0;
      while (starts.size() < 2 * DEPTH && budget < 3000) begin
         in_wr_valid = 0;
         if (acc < DEPTH && $urandom_range(0, 1) == 1) begin
            in_wr_valid = 1; in_wr_data = 6'($urandom);
            if (q.size() < DEPTH) begin
               exp_words.push_back(in_wr_data);
               acc++;
            end
         end
         tick();
         budget++;
      end
      in_wr_valid = 0;
      check("drain_num_starts", 32'(starts.size()), 32'(2 * DEPTH));
      for (int i = 0; i < starts.size() && i < exp_words.size(); i++)
         check("drain_order", 32'(starts[i]), 32'(exp_words[i]));
      wait_idle(200);

      // Reset while a frame is in flight with words queued.
      clear_logs();
      for (int i = 0; i < 6; i++) begin
         in_wr_valid = 1; in_wr_data = 6'(8 + i);
         tick();
      end
      in_wr_valid = 0;
      tick();
      check("rst_pre_level", 32'(out_level), 32'd5);
      in_rst = 1; tick(); in_rst = 0;
      check("rst_level", 32'(out_level), 32'd0);
      check("rst_tx_start", 32'(out_tx_start), 32'd0);
      check("rst_tx_data", 32'(out_tx_data), 32'd0);
      check("rst_overflow", 32'(out_overflow), 32'd0);
      in_tx_done = 1; tick();
      for (int i = 0; i < 6; i++) tick();
      check("rst_stale_done_no_start", 32'(starts.size()), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         in_wr_valid  = ($urandom_range(0, 2) != 0);
         in_wr_data   = 6'($urandom);
         in_ovf_clear = ($urandom_range(0, 15) == 0);
         if (!out_tx_start && $urandom_range(0, 31) == 0) begin
            tx_force = !tx_force;
            in_tx_busy = tx_force || tx_cnt > 0;
         end
         tick();
      end
      in_wr_valid = 0; in_ovf_clear = 0;
      tx_force = 0; in_tx_busy = (tx_cnt > 0);
      wait_idle(1000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Buffered front end for the 6-bit UART transmitter. Accepts 6-bit words from producer logic into a small FIFO, then launches one transmitter frame per word with a single-cycle start pulse, waiting for the transmitter's done pulse before launching the next. Decouples bursty producers from the fixed serial rate and reports fill level and overflow.

Parameters:
DEPTH, 16, FIFO capacity in words; power of two, at least 2.
DEPTH_LOG2, 4, log2(DEPTH); pointer width.
GAP_TICKS, 243, idle clocks between frames; used only with the optional feature.
GAP_TICKS_SIZE, 8, width of the gap counter.

Ports:
in_clk  input  1  clock; all logic on the rising edge.
in_rst  input  1  synchronous reset, active-high.
in_wr_valid  input  1  producer write request.
in_wr_data  input  6  word to enqueue.
out_wr_ready  output  1  high when level < DEPTH.
out_level  output  DEPTH_LOG2+1  words stored, 0..DEPTH.
out_empty  output  1  level == 0.
out_overflow  output  1  sticky; set when a write is dropped.
in_ovf_clear  input  1  clears out_overflow.
out_tx_start  output  1  single-cycle start pulse to the transmitter.
out_tx_data  output  6  word to the transmitter; stable in the start cycle.
in_tx_busy  input  1  transmitter busy.
in_tx_done  input  1  transmitter single-cycle done pulse.
out_idle  output  1  FSM in Q_IDLE and queue empty.

Behaviour:
- Reset (in_rst=1 at an edge): pointers and level = 0, FSM = Q_IDLE, out_tx_start=0, out_tx_data=0, out_overflow=0, gap counter = 0. Reset mid-frame discards queued words and the pending done. The transmitter is reset by the same line.
- Write: accepted at an edge when in_wr_valid && out_wr_ready. Stored at the write pointer, which wraps modulo DEPTH. When full, the write is dropped and out_overflow is set at that edge.
- Overflow: in_ovf_clear has priority over a simultaneous set.
- Pop: occurs only at the edge ending Q_LAUNCH. The read pointer wraps modulo DEPTH.
- Level: a write and a pop at the same edge leave the level unchanged. At full, ready is low, so a concurrent write is dropped even though a pop occurs at the same edge.
- FSM (registered):
  - Q_IDLE -> Q_LAUNCH when !out_empty && !in_tx_busy. out_tx_data is loaded from the FIFO head on this transition.
  - Q_LAUNCH: out_tx_start=1 for exactly one cycle and the head is popped. Then -> Q_WAIT.
  - Q_WAIT: -> Q_GAP (feature enabled) or Q_IDLE when in_tx_done=1; otherwise stay. in_tx_done seen in any other state is ignored.
  - Q_GAP: count 0..GAP_TICKS-1, then -> Q_IDLE with the counter cleared.
- Latency: word written at edge E into an empty queue with the FSM in Q_IDLE gives out_tx_start high in the cycle after edge E+1. Back-to-back words need 1 cycle between in_tx_done and the next start (Q_IDLE -> Q_LAUNCH) without the gap.
- out_tx_data holds its value until the next Q_IDLE -> Q_LAUNCH load.
- out_tx_start never asserts while in_tx_busy=1.
- Outputs out_tx_start and out_idle decode from the state. Level, empty, ready and overflow are registered or decoded from registers, with no combinational input-to-output paths.

Optional Feature:
UART_TXQ_GAP_EN
- Defined: state Q_GAP exists. After each done, the FSM waits GAP_TICKS clocks before returning to Q_IDLE, giving extra stop time.
- Undefined: no Q_GAP and no gap counter. Q_WAIT goes straight to Q_IDLE on in_tx_done. GAP_TICKS and GAP_TICKS_SIZE are unused.

Test Plan:
- Reset, then write 6'h2A at edge E with the transmitter idle -> out_tx_start=1 in the cycle after E+1 with out_tx_data=6'h2A. out_level goes 0 -> 1 -> 0. out_idle=1 after in_tx_done.
- Write 3 words 6'h01, 6'h02, 6'h03 on consecutive cycles; model the transmitter done 10 cycles after each start -> exactly 3 start pulses in order 01, 02, 03, each issued 1 cycle after the previous done (feature off).
- Write DEPTH+2 words while the transmitter is held busy -> out_level=DEPTH, out_wr_ready=0, out_overflow=1 and sticky. Pulse in_ovf_clear -> 0. Assert set and clear in the same cycle -> 0.
- Full queue with a concurrent write at the pop edge -> write dropped, overflow set, level = DEPTH-1. Pointer wrap verified by draining 2*DEPTH words with data matching write order.
- Assert in_rst while in Q_WAIT with 5 words queued -> next cycle out_level=0, out_tx_start=0, out_tx_data=0, out_overflow=0. A stale in_tx_done afterwards produces no start.
- UART_TXQ_GAP_EN defined, GAP_TICKS=4, two words queued -> second out_tx_start comes exactly 4+1 cycles after the first in_tx_done.
